sha3_slot_scheduler: RTL
========================

// Module: sha3_slot_scheduler
// PURPOSE
// - Per-slot controller for 8 interleaved SHA3/SHAKE messages sharing one pipelined Keccak round core.
// - Consumes rate-sized blocks from the slice stage in lockstep with a rotating 3-bit slot index.
// - Sequences each slot: absorb -> 24 rounds -> next block, or squeeze with a digest handshake.
// - Drives padding controls and round/absorb enables; sits between the slice stage and the round core.
// PARAMETERS
// - SLOTS 8 : interleave depth; power of 2; equals round-core pipeline depth.
// - ROUNDS 24 : Keccak-f[1600] rounds per permutation.
// - SHAKE128_OUT 256 : SHAKE128 output bits; must be <= 1344.
// - SHAKE256_OUT 512 : SHAKE256 output bits; must be <= 1088.
// PORTS
// - clk          in   1   clock
// - rst          in   1   reset, asynchronous, active-high
// - slot_idx     out  3   slot served this cycle; the slice stage and core follow it
// - in_valid     in   1   block present for slot_idx
// - in_ready     out  1   slot_idx is IDLE or ABSORB
// - in_mode      in   2   0 sha3-256, 1 sha3-512, 2 shake128, 3 shake256
// - in_len       in   11  valid bits in the block; 0 is legal only when in_last=1 (pad-only block)
// - in_last      in   1   final block of the message
// - absorb_en    out  1   XOR the block into the slot state
// - pad_en       out  1   apply padding to this block
// - pad_suffix   out  8   0x06 (sha3) or 0x1F (shake), inserted at bit pad_pos
// - pad_pos      out  11  = in_len
// - pad_end      out  11  = rate-1; OR 1 into this bit
// - round_en     out  1   core executes one round for slot_idx
// - round_idx    out  5   0..23
// - state_clear  out  1   zero the slot state (release after squeeze)
// - digest_valid out  1   slot_idx digest available at core output
// - digest_mode  out  2   mode of the digest slot
// - digest_bits  out  11  256/512/SHAKE128_OUT/SHAKE256_OUT
// - digest_ready in   1   sink accepts the digest
// BEHAVIOUR
// - slot_idx: resets to 0; increments every cycle and wraps 7->0. All per-slot actions happen only on that slot's turn.
// - Per-slot context: state, round counter (5b), last flag, mode (2b). State and round counter reset to IDLE/0.
// - Reset values: all outputs 0 except pad_end = rate(mode 0)-1 = 1087, which is combinational.
// - rate: mode 0 1088, 1 576, 2 1344, 3 1088. Latched at the first block. in_mode is ignored on later blocks.
// - IDLE: on in_valid, latch mode and go to ABSORB, handling the block the same cycle.
// - ABSORB:
//   - Nothing happens if in_valid=0.
//   - If in_valid=1: absorb_en=1, round_en=1, round_idx=0, last<=in_last; go to PERMUTE with round=1.
//   - If in_last=1: also pad_en=1.
//   - in_len==rate with in_last=1 is illegal (the slice sends a 0-length block instead); flag it with an assertion.
// - PERMUTE: round_en=1, round_idx=round on each turn. After round 23, go to SQUEEZE if last, else ABSORB.
// - SQUEEZE:
//   - digest_valid=1 on each turn until digest_ready is seen on that turn.
//   - On acceptance: state_clear=1, go to IDLE.
//   - digest_ready outside the slot's turn is ignored.
// - in_ready=0 in PERMUTE/SQUEEZE; in_valid is then ignored and no output asserts.
// - Latency:
//   - A block absorbed at cycle t gets its rounds on t, t+8, ..., t+184.
//   - Next absorb or digest is at t+192.
//   - A single-block message absorbed at t has digest_valid at t+192.
// - Slots are independent. Modes may differ per slot. A slot never blocks others.
// - Reset mid-operation: all contexts go to IDLE and slot_idx to 0. Partial messages are discarded without digest.
// - Round counter width 5b, compare ==ROUNDS-1. pad_pos and pad_end use 11b; no overflow since rate <= 1344.
// STRUCTURE
// - Package sha3_pkg:
//   - slot_state_t {IDLE, ABSORB, PERMUTE, SQUEEZE}
//   - RATE_* constants, SUFFIX_SHA3=8'h06, SUFFIX_SHAKE=8'h1F, ROUNDS, mode encodings, digest length function
// - Sub-module sha3_slot_ctx: 8-entry context register file.
//   - Read port addressed by slot_idx.
//   - Write port updating the same entry each cycle.
//   - Top-level holds the slot counter plus the combinational next-state/output logic.
// TESTING
// - Reset, then one sha3-256 message on slot 0 (in_len=200, last) at cycle 0:
//   - pad_en=1, pad_pos=200, pad_end=1087.
//   - round_idx 0..23 on cycles 0,8,...,184.
//   - digest_valid at cycle 192 with digest_bits=256.
// - Two-block shake128 on slot 3: block 1 in_len=1344 not last, block 2 in_len=0 last.
//   - The second absorb is accepted exactly 192 cycles later with pad_pos=0, pad_end=1343.
// - digest_ready held low on slot 5 for 3 turns:
//   - digest_valid re-asserts at t, t+8, t+16, t+24.
//   - state_clear is asserted only on the accepted turn; afterwards in_ready=1.
// - All 8 slots started in cycles 0-7 with mixed modes:
//   - 8 digests at cycles 192-199, in slot order, with correct digest_mode/digest_bits.
// - in_valid during PERMUTE: in_ready=0, with absorb_en and pad_en staying 0 and no context change.
// - rst asserted at cycle 100 mid-permutation: all outputs 0 that same cycle, slot_idx=0, no digest ever emitted.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3/SHAKE slot scheduler.
package sha3_pkg;

  typedef enum logic [1:0] {IDLE, ABSORB, PERMUTE, SQUEEZE} slot_state_t;

  localparam logic [1:0] MODE_SHA3_256 = 2'd0;
  localparam logic [1:0] MODE_SHA3_512 = 2'd1;
  localparam logic [1:0] MODE_SHAKE128 = 2'd2;
  localparam logic [1:0] MODE_SHAKE256 = 2'd3;

  localparam logic [10:0] RATE_SHA3_256 = 11'd1088;
  localparam logic [10:0] RATE_SHA3_512 = 11'd576;
  localparam logic [10:0] RATE_SHAKE128 = 11'd1344;
  localparam logic [10:0] RATE_SHAKE256 = 11'd1088;

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

  localparam int ROUNDS = 24;

  // One slot's context: FSM state, next round to run, final-block flag, mode.
  typedef struct packed {
    slot_state_t state;
    logic [4:0]  rnd;
    logic        last;
    logic [1:0]  mode;
  } slot_ctx_t;

  function automatic logic [10:0] rate_of(input logic [1:0] mode);
    case (mode)
      MODE_SHA3_256: rate_of = RATE_SHA3_256;
      MODE_SHA3_512: rate_of = RATE_SHA3_512;
      MODE_SHAKE128: rate_of = RATE_SHAKE128;
      default:       rate_of = RATE_SHAKE256;
    endcase
  endfunction

  // Both SHAKE modes have mode[1] set.
  function automatic logic [7:0] suffix_of(input logic [1:0] mode);
    suffix_of = mode[1] ? SUFFIX_SHAKE : SUFFIX_SHA3;
  endfunction

  function automatic logic [10:0] digest_bits_of(input logic [1:0] mode,
                                                 input int s128, input int s256);
    case (mode)
      MODE_SHA3_256: digest_bits_of = 11'd256;
      MODE_SHA3_512: digest_bits_of = 11'd512;
      MODE_SHAKE128: digest_bits_of = 11'(s128);
      default:       digest_bits_of = 11'(s256);
    endcase
  endfunction

endpackage

// File: rtl/sha3_slot_ctx.sv
// Per-slot context register file: one read and one write port, both on the
// entry of the slot currently being served.
module sha3_slot_ctx
  import sha3_pkg::*;
#(
  parameter int SLOTS = 8,
  localparam int SW   = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] addr_i,
  input  slot_ctx_t     wr_i,
  output slot_ctx_t     rd_o
);

  slot_ctx_t ent [SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_ent
    slot_ctx_t ent_q;
    // Entry g only changes on its own turn; reset drops it back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  ent_q <= '0;
      else if (addr_i == SW'(g)) ent_q <= wr_i;
    end
    assign ent[g] = ent_q;
  end

  assign rd_o = ent[addr_i];

endmodule

// File: rtl/sha3_slot_scheduler.sv
// Time-multiplexed controller for SLOTS interleaved SHA3/SHAKE messages
// sharing one pipelined Keccak round core. Each cycle serves one slot.
module sha3_slot_scheduler #(
  parameter int SLOTS        = 8,
  parameter int ROUNDS       = 24,
  parameter int SHAKE128_OUT = 256,
  parameter int SHAKE256_OUT = 512,
  localparam int SW          = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [SW-1:0] slot_idx,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_mode,
  input  logic [10:0]   in_len,
  input  logic          in_last,
  output logic          absorb_en,
  output logic          pad_en,
  output logic [7:0]    pad_suffix,
  output logic [10:0]   pad_pos,
  output logic [10:0]   pad_end,
  output logic          round_en,
  output logic [4:0]    round_idx,
  output logic          state_clear,
  output logic          digest_valid,
  output logic [1:0]    digest_mode,
  output logic [10:0]   digest_bits,
  input  logic          digest_ready
);
  import sha3_pkg::*;

  logic [SW-1:0] slot_q;
  slot_ctx_t     cur, nxt;
  logic          vld;
  logic [1:0]    eff_mode;

  // Rotating slot pointer; the slice stage and round core follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_q + 1'b1;
  end

  assign slot_idx = slot_q;

  sha3_slot_ctx #(.SLOTS(SLOTS)) u_ctx (
    .clk    (clk),
    .rst    (rst),
    .addr_i (slot_q),
    .wr_i   (nxt),
    .rd_o   (cur)
  );

  // Keeps the same-cycle outputs quiet while reset is held.
  assign vld = in_valid & ~rst;

  // Next context and per-turn strobes for the slot being served.
  always_comb begin
    nxt          = cur;
    eff_mode     = cur.mode;
    in_ready     = 1'b0;
    absorb_en    = 1'b0;
    pad_en       = 1'b0;
    round_en     = 1'b0;
    round_idx    = '0;
    state_clear  = 1'b0;
    digest_valid = 1'b0;
    unique case (cur.state)
      IDLE, ABSORB: begin
        in_ready = ~rst;
        if (vld) begin
          // Mode is captured only from the first block of a message.
          if (cur.state == IDLE) begin
            eff_mode = in_mode;
            nxt.mode = in_mode;
          end
          absorb_en = 1'b1;
          round_en  = 1'b1;
          pad_en    = in_last;
          nxt.last  = in_last;
          nxt.state = PERMUTE;
          nxt.rnd   = 5'd1;
        end
      end
      PERMUTE: begin
        round_en  = 1'b1;
        round_idx = cur.rnd;
        if (cur.rnd == 5'(ROUNDS - 1)) begin
          nxt.rnd   = '0;
          nxt.state = cur.last ? SQUEEZE : ABSORB;
        end else begin
          nxt.rnd = cur.rnd + 5'd1;
        end
      end
      SQUEEZE: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          state_clear = 1'b1;
          nxt         = '0;
        end
      end
      default: nxt = '0;
    endcase
  end

  assign pad_pos     = pad_en ? in_len : '0;
  assign pad_suffix  = pad_en ? suffix_of(eff_mode) : '0;
  assign pad_end     = rate_of(eff_mode) - 11'd1;
  assign digest_mode = digest_valid ? cur.mode : '0;
  assign digest_bits = digest_valid ? digest_bits_of(cur.mode, SHAKE128_OUT, SHAKE256_OUT) : '0;

  // A full-rate final block leaves no room for the pad bits; the slice
  // stage must send an extra zero-length block instead.
  a_full_rate_last : assert property (@(posedge clk) disable iff (rst)
    (vld && in_ready && in_last) |-> (in_len != rate_of(eff_mode)));

endmodule
